mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares one single-ported unified memory between the 5-stage core's instruction port and data port. Sits between `riscv_32i` and memory and drives the core's `Iwait`/`Dwait` stall inputs. Data accesses have fixed priority over fetches. A completed response is held until the pipeline advances, so a fetch is not repeated while a data access is outstanding.

## Interface
- `ADDR_W`, default 32: byte address width.
- `DATA_W`, default 32: data width; the mask is `DATA_W/8` bits.
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high reset.
- `pc_imem` in ADDR_W: fetch address; held stable while `Iwait`=1.
- `imem_req` in 1: fetch request.
- `imem_instn` out DATA_W: fetched instruction.
- `Iwait` out 1: fetch not yet complete.
- `dmem_req`, `dmem_we` in 1: data access and write select.
- `dmem_addr`, `dmem_wd` in ADDR_W/DATA_W: data address and write data; held stable while `Dwait`=1.
- `dmem_mask` in DATA_W/8: byte enables.
- `dmem_rd` out DATA_W: load data.
- `Dwait` out 1: data access not yet complete.
- `mem_req` out 1: memory request, registered.
- `mem_we` out 1: memory write enable, registered.
- `mem_addr` out ADDR_W: memory address, registered.
- `mem_wd` out DATA_W: memory write data, registered.
- `mem_mask` out DATA_W/8: memory byte enables, registered.
- `mem_rdata` in DATA_W: memory read data.
- `mem_ready` in 1: one-cycle completion pulse; `mem_rdata` is valid in the same cycle.
- `perf_igrant`, `perf_dgrant`, `perf_conflict` out 32: performance counters.

## Operation
- FSM states: `ARB_IDLE`, `ARB_IBUSY`, `ARB_DBUSY`. Reset state is `ARB_IDLE`.
- Pending requests:
  - `d_pend` = `dmem_req & !dbuf_v`.
  - `i_pend` = `imem_req & !ibuf_v`.
- Arbitration (`ARB_IDLE`): if `d_pend`, go to `ARB_DBUSY`; else if `i_pend`, go to `ARB_IBUSY`. On grant, latch the selected port's address, write data, mask and we into the `mem_*` registers and set `mem_req`=1. Instruction grants drive `mem_we`=0 and `mem_mask`=all ones.
- Busy states:
  - `mem_req` stays high and `mem_*` stay stable until `mem_ready`.
  - On `mem_ready`, re-arbitrate in the same edge, excluding the port just served. If the other port is pending, grant it directly (back-to-back; `mem_req` stays 1). Otherwise return to `ARB_IDLE` with `mem_req`=0.
- Completion flags:
  - `i_done` = `ibuf_v | (state==ARB_IBUSY & mem_ready)`.
  - `d_done` = `dbuf_v | (state==ARB_DBUSY & mem_ready)`.
- Waits (combinational):
  - `Iwait` = `imem_req & !i_done`.
  - `Dwait` = `dmem_req & !d_done`.
- Data outputs:
  - `imem_instn` = `ibuf_v ? ibuf : mem_rdata`.
  - `dmem_rd` = `dbuf_v ? dbuf : mem_rdata`.
- Advance: `adv` = `!Iwait & !Dwait`; the pipeline moves only in such a cycle.
- Buffer update:
  - If `adv`, clear both `ibuf_v` and `dbuf_v` (responses consumed).
  - Otherwise, on `mem_ready`, load the served port's buffer with `mem_rdata` and set its valid. Stores also set `dbuf_v`.
- A fetch completing while a load is pending is therefore buffered, not refetched.

## Timing
- Reset values: state `ARB_IDLE`; `mem_req`, `mem_we`, `mem_addr`, `mem_wd`, `mem_mask` = 0; `ibuf_v`=`dbuf_v`=0; counters 0.
- With both requests low after reset, `Iwait`=`Dwait`=0 and `imem_instn`=`dmem_rd`=`mem_rdata`.
- Minimum latency from request to wait release: 1 cycle (grant register) + memory latency. With `mem_ready` one cycle after `mem_req` rises, the wait is high for 2 cycles.
- `mem_ready` while in `ARB_IDLE` is ignored.
- Simultaneous new requests: data wins; the fetch is granted on the data `mem_ready` edge.
- Reset mid-transaction: `mem_req` drops next edge and the transaction is abandoned; memory is reset by the same `reset`.
- `imem_req`=0 with `ibuf_v`=1: `ibuf_v` clears on the next `adv`.

## Configuration
- `MEM_ARB_PERF_EN` defined:
  - `perf_igrant` / `perf_dgrant` increment on each instruction / data grant.
  - `perf_conflict` increments each cycle with `i_pend & d_pend`.
  - All three wrap at 2^32 and are cleared by `reset`.
- Undefined: the three ports are tied to 0 and no counter flops exist.

## Structure
- `mem_arb_pkg`: `arb_state_t` enum (`ARB_IDLE`, `ARB_IBUSY`, `ARB_DBUSY`) and the `ARB_MASK_ALL` constant.
- Sub-module `mem_arb_resp_buf` (valid + data register; load, clear and bypass mux), instantiated once per port.

## Test plan
- Fetch only: `pc_imem`=0x100; `mem_ready` one cycle after `mem_req` with `mem_rdata`=0x00500093 -> `Iwait` high 2 cycles, then low with `imem_instn`=0x00500093; `perf_igrant`=1.
- Simultaneous: `dmem_req` load @0x2000 and fetch @0x104 -> data granted first, fetch back-to-back; `Dwait` releases before `Iwait`; `perf_conflict`≥1.
- Buffering: fetch completes while load pending 3 more cycles -> no second fetch on `mem_addr`; `imem_instn` stable from `ibuf`; both buffers clear on the first `adv` cycle.
- Store: `dmem_we`=1, addr 0x3000, wd 0xDEADBEEF, mask 4'b0011 -> `mem_we`=1, `mem_mask`=0011, `mem_wd`=0xDEADBEEF held until `mem_ready`.
- Reset mid-op: assert `reset` in `ARB_DBUSY` -> next edge `mem_req`=0, state `ARB_IDLE`, buffers invalid, counters 0.
- Macro off: `perf_*` read 0 throughout the conflict scenario.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_IBUSY = 2'd1,
    ARB_DBUSY = 2'd2
  } arb_state_t;

  // Wide enough for any supported DATA_W; users slice the low DATA_W/8 bits.
  localparam logic [63:0] ARB_MASK_ALL = '1;

endpackage

// File: rtl/mem_arb_resp_buf.sv
// Per-port response holding register: captures a completed read until the pipeline advances,
// otherwise passes the live memory read data straight through.
module mem_arb_resp_buf #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              clear,
  input  logic [DATA_W-1:0] memData,
  output logic              valid,
  output logic [DATA_W-1:0] data
);

  logic [DATA_W-1:0] bufData;

  // Clear wins: an advance consumes the response even if it completes this cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid   <= 1'b0;
      bufData <= '0;
    end else if (clear) begin
      valid   <= 1'b0;
    end else if (load) begin
      valid   <= 1'b1;
      bufData <= memData;
    end
  end

  assign data = valid ? bufData : memData;

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the core's fetch and data ports onto one single-ported memory, data first.
// Define MEM_ARB_PERF_EN to build the grant/conflict performance counters.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   pc_imem,
  input  logic                imem_req,
  output logic [DATA_W-1:0]   imem_instn,
  output logic                Iwait,
  input  logic                dmem_req,
  input  logic                dmem_we,
  input  logic [ADDR_W-1:0]   dmem_addr,
  input  logic [DATA_W-1:0]   dmem_wd,
  input  logic [DATA_W/8-1:0] dmem_mask,
  output logic [DATA_W-1:0]   dmem_rd,
  output logic                Dwait,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wd,
  output logic [DATA_W/8-1:0] mem_mask,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_ready,
  output logic [31:0]         perf_igrant,
  output logic [31:0]         perf_dgrant,
  output logic [31:0]         perf_conflict
);

  localparam int unsigned MASK_W = DATA_W / 8;
  localparam logic [MASK_W-1:0] MaskAll = ARB_MASK_ALL[MASK_W-1:0];

  arb_state_t state;

  logic ibufV, dbufV;
  logic iPend, dPend;
  logic iServed, dServed;
  logic iDone, dDone;
  logic adv;
  logic grantI, grantD, release_;

  assign iPend   = imem_req & ~ibufV;
  assign dPend   = dmem_req & ~dbufV;
  assign iServed = (state == ARB_IBUSY) & mem_ready;
  assign dServed = (state == ARB_DBUSY) & mem_ready;
  assign iDone   = ibufV | iServed;
  assign dDone   = dbufV | dServed;
  assign Iwait   = imem_req & ~iDone;
  assign Dwait   = dmem_req & ~dDone;
  assign adv     = ~Iwait & ~Dwait;

  // On completion the port just served is excluded, so the other one goes back-to-back.
  always_comb begin
    grantI   = 1'b0;
    grantD   = 1'b0;
    release_ = 1'b0;
    unique case (state)
      ARB_IDLE: begin
        grantD = dPend;
        grantI = ~dPend & iPend;
      end
      ARB_IBUSY: begin
        if (mem_ready) begin
          grantD   = dPend;
          release_ = ~dPend;
        end
      end
      ARB_DBUSY: begin
        if (mem_ready) begin
          grantI   = iPend;
          release_ = ~iPend;
        end
      end
      default: release_ = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ARB_IDLE;
      mem_req  <= 1'b0;
      mem_we   <= 1'b0;
      mem_addr <= '0;
      mem_wd   <= '0;
      mem_mask <= '0;
    end else if (grantD) begin
      state    <= ARB_DBUSY;
      mem_req  <= 1'b1;
      mem_we   <= dmem_we;
      mem_addr <= dmem_addr;
      mem_wd   <= dmem_wd;
      mem_mask <= dmem_mask;
    end else if (grantI) begin
      state    <= ARB_IBUSY;
      mem_req  <= 1'b1;
      mem_we   <= 1'b0;
      mem_addr <= pc_imem;
      mem_wd   <= '0;
      mem_mask <= MaskAll;
    end else if (release_) begin
      state    <= ARB_IDLE;
      mem_req  <= 1'b0;
    end
  end

  mem_arb_resp_buf #(
    .DATA_W (DATA_W)
  ) u_ibuf (
    .clk     (clk),
    .reset   (reset),
    .load    (iServed),
    .clear   (adv),
    .memData (mem_rdata),
    .valid   (ibufV),
    .data    (imem_instn)
  );

  // Stores set the valid flag too; the captured read data is simply unused.
  mem_arb_resp_buf #(
    .DATA_W (DATA_W)
  ) u_dbuf (
    .clk     (clk),
    .reset   (reset),
    .load    (dServed),
    .clear   (adv),
    .memData (mem_rdata),
    .valid   (dbufV),
    .data    (dmem_rd)
  );

`ifdef MEM_ARB_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_igrant   <= '0;
      perf_dgrant   <= '0;
      perf_conflict <= '0;
    end else begin
      if (grantI) perf_igrant <= perf_igrant + 32'd1;
      if (grantD) perf_dgrant <= perf_dgrant + 32'd1;
      if (iPend & dPend) perf_conflict <= perf_conflict + 32'd1;
    end
  end
`else
  assign perf_igrant   = 32'd0;
  assign perf_dgrant   = 32'd0;
  assign perf_conflict = 32'd0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios with literal expectations, then a randomized
// core/memory run checked every cycle against a transaction-level model.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_imem;
  logic        imem_req;
  logic [31:0] imem_instn;
  logic        Iwait;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wd;
  logic [3:0]  dmem_mask;
  logic [31:0] dmem_rd;
  logic        Dwait;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wd;
  logic [3:0]  mem_mask;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic [31:0] perf_igrant, perf_dgrant, perf_conflict;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk           (clk),
    .reset         (reset),
    .pc_imem       (pc_imem),
    .imem_req      (imem_req),
    .imem_instn    (imem_instn),
    .Iwait         (Iwait),
    .dmem_req      (dmem_req),
    .dmem_we       (dmem_we),
    .dmem_addr     (dmem_addr),
    .dmem_wd       (dmem_wd),
    .dmem_mask     (dmem_mask),
    .dmem_rd       (dmem_rd),
    .Dwait         (Dwait),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wd        (mem_wd),
    .mem_mask      (mem_mask),
    .mem_rdata     (mem_rdata),
    .mem_ready     (mem_ready),
    .perf_igrant   (perf_igrant),
    .perf_dgrant   (perf_dgrant),
    .perf_conflict (perf_conflict)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] memWord(input logic [31:0] a);
    if (a == 32'h100) return 32'h0050_0093;
    return a * 32'h9E37_79B1 + 32'h0123_4567;
  endfunction

  // Memory: counts memLat cycles (random 1..3 when 0) of visible mem_req, then pulses mem_ready.
  int memLat = 1;
  bit spurEn = 1'b0;
  bit memBusy = 1'b0;
  int memCnt = 0;
  logic rstSeen;

  initial begin
    mem_ready = 1'b0;
    mem_rdata = 32'h0;
  end

  always begin
    @(posedge clk);
    rstSeen = reset;
    #1;
    if (rstSeen) begin
      memBusy   = 1'b0;
      mem_ready = 1'b0;
    end else begin
      if (mem_ready) memBusy = 1'b0;
      mem_ready = 1'b0;
      if (mem_req && !memBusy) begin
        memBusy = 1'b1;
        memCnt  = (memLat != 0) ? memLat : int'($urandom_range(1, 3));
      end else if (memBusy) begin
        memCnt--;
        if (memCnt == 0) mem_ready = 1'b1;
      end else if (!mem_req && spurEn && $urandom_range(0, 7) == 0) begin
        mem_ready = 1'b1;
      end
    end
    mem_rdata = (mem_ready && memBusy) ? memWord(mem_addr) : $urandom;
  end

  // Transaction-level model: which port owns the memory, and which responses are held.
  int          mCur = 0;  // 0 none, 1 fetch, 2 data
  logic [31:0] mAddr, mWd;
  logic        mWe;
  logic [3:0]  mMask;
  bit          mIHave = 0, mDHave = 0;
  logic [31:0] mIData, mDData;
  logic [31:0] mIG = 0, mDG = 0, mConf = 0;
  bit          lastAdv = 0;

  always @(negedge clk) begin
    bit iDn, dDn, eIw, eDw, iP, dP;
    int served;
    iDn = mIHave || (mCur == 1 && mem_ready);
    dDn = mDHave || (mCur == 2 && mem_ready);
    eIw = imem_req && !iDn;
    eDw = dmem_req && !dDn;
    check("Iwait", {31'b0, Iwait}, {31'b0, eIw});
    check("Dwait", {31'b0, Dwait}, {31'b0, eDw});
    check("imem_instn", imem_instn, mIHave ? mIData : mem_rdata);
    check("dmem_rd", dmem_rd, mDHave ? mDData : mem_rdata);
    check("mem_req", {31'b0, mem_req}, {31'b0, mCur != 0});
    if (mCur != 0) begin
      check("mem_addr", mem_addr, mAddr);
      check("mem_we", {31'b0, mem_we}, {31'b0, mWe});
      check("mem_mask", {28'b0, mem_mask}, {28'b0, mMask});
      if (mCur == 2) check("mem_wd", mem_wd, mWd);
    end
`ifdef MEM_ARB_PERF_EN
    check("perf_igrant", perf_igrant, mIG);
    check("perf_dgrant", perf_dgrant, mDG);
    check("perf_conflict", perf_conflict, mConf);
`else
    check("perf_igrant", perf_igrant, 32'd0);
    check("perf_dgrant", perf_dgrant, 32'd0);
    check("perf_conflict", perf_conflict, 32'd0);
`endif
    lastAdv = !eIw && !eDw;
    iP = imem_req && !mIHave;
    dP = dmem_req && !mDHave;
    if (reset) begin
      mCur = 0; mIHave = 0; mDHave = 0; mIG = 0; mDG = 0; mConf = 0;
    end else begin
      if (iP && dP) mConf++;
      served = mem_ready ? mCur : 0;
      if (lastAdv) begin
        mIHave = 0;
        mDHave = 0;
      end else if (served == 1) begin
        mIHave = 1; mIData = mem_rdata;
      end else if (served == 2) begin
        mDHave = 1; mDData = mem_rdata;
      end
      if (mCur == 0 || served != 0) begin
        if (dP && served != 2) begin
          mCur = 2; mAddr = dmem_addr; mWe = dmem_we; mWd = dmem_wd; mMask = dmem_mask; mDG++;
        end else if (iP && served != 1) begin
          mCur = 1; mAddr = pc_imem; mWe = 0; mMask = 4'hF; mIG++;
        end else begin
          mCur = 0;
        end
      end
    end
  end

  task automatic nextCyc();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic dropReqs();
    imem_req = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
  endtask

  initial begin
    logic [31:0] r;
    bit renew;
    reset = 1'b1;
    pc_imem = 32'h0; dmem_addr = 32'h0; dmem_wd = 32'h0; dmem_mask = 4'h0;
    dropReqs();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    sample();
    check("rst mem_req", {31'b0, mem_req}, 32'd0);
    check("rst mem_we", {31'b0, mem_we}, 32'd0);
    check("rst mem_addr", mem_addr, 32'd0);
    check("rst mem_wd", mem_wd, 32'd0);
    check("rst mem_mask", {28'b0, mem_mask}, 32'd0);
    check("rst Iwait", {31'b0, Iwait}, 32'd0);
    check("rst Dwait", {31'b0, Dwait}, 32'd0);
    check("rst imem_instn bypass", imem_instn, mem_rdata);
    check("rst dmem_rd bypass", dmem_rd, mem_rdata);

    // Fetch only
    nextCyc(); imem_req = 1'b1; pc_imem = 32'h100;
    sample(); check("f0 Iwait", {31'b0, Iwait}, 32'd1);
    nextCyc(); sample();
    check("f1 Iwait", {31'b0, Iwait}, 32'd1);
    check("f1 mem_addr", mem_addr, 32'h100);
    check("f1 mem_mask", {28'b0, mem_mask}, 32'hF);
    nextCyc(); sample();
    check("f2 Iwait", {31'b0, Iwait}, 32'd0);
    check("f2 imem_instn", imem_instn, 32'h0050_0093);
    nextCyc(); dropReqs(); sample();
`ifdef MEM_ARB_PERF_EN
    check("f perf_igrant", perf_igrant, 32'd1);
`else
    check("f perf_igrant", perf_igrant, 32'd0);
`endif

    // Simultaneous load and fetch: data first, fetch back-to-back
    nextCyc();
    dmem_req = 1'b1; dmem_we = 1'b0; dmem_addr = 32'h2000; imem_req = 1'b1; pc_imem = 32'h104;
    sample(); check("s0 Dwait", {31'b0, Dwait}, 32'd1);
    nextCyc(); sample(); check("s1 mem_addr", mem_addr, 32'h2000);
    nextCyc(); sample();
    check("s2 Dwait", {31'b0, Dwait}, 32'd0);
    check("s2 Iwait", {31'b0, Iwait}, 32'd1);
    nextCyc(); sample();
    check("s3 mem_addr", mem_addr, 32'h104);
    check("s3 mem_req", {31'b0, mem_req}, 32'd1);
    check("s3 dmem_rd held", dmem_rd, memWord(32'h2000));
    nextCyc(); sample();
    check("s4 Iwait", {31'b0, Iwait}, 32'd0);
    check("s4 imem_instn", imem_instn, memWord(32'h104));
`ifdef MEM_ARB_PERF_EN
    check("s perf_conflict>=1", {31'b0, perf_conflict >= 32'd1}, 32'd1);
`else
    check("s perf_conflict", perf_conflict, 32'd0);
`endif
    nextCyc(); dropReqs();

    // Fetch completes while a slow load is still pending
    nextCyc(); imem_req = 1'b1; pc_imem = 32'h108;
    nextCyc(); dmem_req = 1'b1; dmem_we = 1'b0; dmem_addr = 32'h2004;
    nextCyc(); memLat = 4; sample();
    check("b2 Iwait", {31'b0, Iwait}, 32'd0);
    check("b2 Dwait", {31'b0, Dwait}, 32'd1);
    for (int k = 0; k < 4; k++) begin
      nextCyc(); sample();
      check("b mem_addr no refetch", mem_addr, 32'h2004);
      check("b imem_instn held", imem_instn, memWord(32'h108));
      check("b Dwait", {31'b0, Dwait}, 32'd1);
    end
    nextCyc(); sample();
    check("b7 Dwait", {31'b0, Dwait}, 32'd0);
    check("b7 dmem_rd", dmem_rd, memWord(32'h2004));
    nextCyc(); dropReqs(); sample();
    check("b8 ibuf cleared", imem_instn, mem_rdata);
    check("b8 dbuf cleared", dmem_rd, mem_rdata);

    // Store held until mem_ready
    nextCyc(); memLat = 3;
    dmem_req = 1'b1; dmem_we = 1'b1; dmem_addr = 32'h3000; dmem_wd = 32'hDEAD_BEEF;
    dmem_mask = 4'b0011;
    for (int k = 0; k < 3; k++) begin
      nextCyc(); sample();
      check("st mem_we", {31'b0, mem_we}, 32'd1);
      check("st mem_mask", {28'b0, mem_mask}, 32'h3);
      check("st mem_wd", mem_wd, 32'hDEAD_BEEF);
      check("st Dwait", {31'b0, Dwait}, 32'd1);
    end
    nextCyc(); sample(); check("st done Dwait", {31'b0, Dwait}, 32'd0);
    nextCyc(); dropReqs();

    // Reset while a load is in flight
    nextCyc(); dmem_req = 1'b1; dmem_we = 1'b0; dmem_addr = 32'h2008;
    nextCyc(); sample(); check("r1 mem_req", {31'b0, mem_req}, 32'd1);
    nextCyc(); reset = 1'b1; dropReqs();
    nextCyc(); reset = 1'b0; sample();
    check("r mem_req", {31'b0, mem_req}, 32'd0);
    check("r dmem_rd bypass", dmem_rd, mem_rdata);
    check("r perf_igrant", perf_igrant, 32'd0);
    check("r perf_dgrant", perf_dgrant, 32'd0);
    check("r perf_conflict", perf_conflict, 32'd0);

    // Randomized core and memory
    memLat = 0;
    spurEn = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      nextCyc();
      renew = lastAdv || reset;
      if (reset) reset = 1'b0;
      else if ($urandom_range(0, 199) == 0) reset = 1'b1;
      if (renew) begin
        imem_req  = ($urandom_range(0, 3) != 0);
        r = $urandom; pc_imem = {r[31:2], 2'b00};
        dmem_req  = ($urandom_range(0, 1) != 0);
        dmem_we   = ($urandom_range(0, 2) == 0);
        r = $urandom; dmem_addr = {r[31:2], 2'b00};
        dmem_wd   = $urandom;
        r = $urandom; dmem_mask = r[3:0];
      end
    end

    sample();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
